// File: rtl/mips_mem_pkg.sv
// Shared encodings and byte-lane helpers for the MEM stage.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Load selection captured at completion; drives the extender on the RAM output.
    typedef struct packed {
        logic       en;
        logic [1:0] size;
        logic [1:0] lane;
        logic       uns;
    } ld_sel_t;

    // Per-byte write enables; size 11 behaves as a word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B:  return 4'b0001 << lane;
            SIZE_H:  return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data so every enabled lane sees the right bytes.
    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SIZE_B:  return {4{data[7:0]}};
            SIZE_H:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

    // Shift the addressed lane(s) down and sign/zero extend; words pass through.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SIZE_B:  return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_H:  return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_be.sv
// Single-port synchronous word RAM with byte write enables; the read port
// returns the contents from before any write in the same cycle.
module data_ram_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Read old word and apply enabled byte writes on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int k = 0; k < 4; k++) begin
                if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_ls.sv
// MEM stage: byte/half/word loads and stores with optional wait states,
// misalignment detection and registered MEM/WB outputs.
module mem_access_ls
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic              branch_in,
    input  logic              jump_in,
    input  logic              zero_in,
    input  logic [31:0]       branch_pc_in,
    input  logic [31:0]       address_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        rd_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic              MemtoReg_out,
    output logic              RegWrite_out,
    output logic [DATA_W-1:0] load_data_out,
    output logic [31:0]       alu_result_out,
    output logic [4:0]        rd_out,
    output logic              PCSrc_out,
    output logic              jump_out,
    output logic [31:0]       branch_pc_out,
    output logic              misaligned_out
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES);
    localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);

    state_t      state, state_nx;
    logic [2:0]  cnt;          // cycles left in WAIT, including the current one
    logic        mem_op, mis, access, start_wait, complete;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    ld_sel_t     ld_q;

    assign mem_op     = MemRead | MemWrite;
    assign mis        = mem_op & is_misaligned(mem_size, address_in[1:0]);
    assign access     = mem_op & ~mis;
    assign start_wait = (state == ST_IDLE) & valid_in & access & HAS_WAIT;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (start_wait)
                cnt <= CNT_LOAD;
            else if (state == ST_WAIT)
                cnt <= cnt - 3'd1;
        end
    end

    // Next state: enter WAIT on an aligned access, leave on the last wait cycle.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start_wait) state_nx = ST_WAIT;
            ST_WAIT: if (cnt == 3'd1) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: completion strobe and stall to the hazard unit.
    always_comb begin
        complete  = 1'b0;
        stall_out = 1'b0;
        case (state)
            ST_IDLE: begin
                complete  = valid_in & (~access | ~HAS_WAIT);
                stall_out = start_wait;
            end
            ST_WAIT: begin
                complete  = (cnt == 3'd1);
                stall_out = (cnt != 3'd1);
            end
            default: ;
        endcase
        if (!rst_n) begin
            complete  = 1'b0;
            stall_out = 1'b0;
        end
    end

    // RAM is touched only in the completion cycle so its output lines up
    // with the registered load selection and then holds across bubbles.
    assign ram_en = complete & access;
    assign ram_we = (ram_en & MemWrite) ? byte_enable(mem_size, address_in[1:0]) : 4'b0000;

    data_ram_be #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (address_in[AW+1:2]),
        .wdata (store_align(store_data_in, mem_size)),
        .rdata (ram_rdata)
    );

    // MEM/WB register: load on completion, bubble otherwise with data held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out      <= 1'b0;
            MemtoReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            alu_result_out <= '0;
            rd_out         <= '0;
            PCSrc_out      <= 1'b0;
            jump_out       <= 1'b0;
            branch_pc_out  <= '0;
            misaligned_out <= 1'b0;
            ld_q           <= '0;
        end else if (complete) begin
            valid_out      <= 1'b1;
            MemtoReg_out   <= MemtoReg_in;
            RegWrite_out   <= RegWrite_in & ~mis;
            alu_result_out <= address_in;
            rd_out         <= rd_in;
            PCSrc_out      <= branch_in & zero_in;
            jump_out       <= jump_in;
            branch_pc_out  <= branch_pc_in;
            misaligned_out <= mis;
            ld_q           <= '{en: MemRead & ~mis, size: mem_size,
                                lane: address_in[1:0], uns: mem_unsigned};
        end else begin
            valid_out      <= 1'b0;
            RegWrite_out   <= 1'b0;
            PCSrc_out      <= 1'b0;
            jump_out       <= 1'b0;
            misaligned_out <= 1'b0;
        end
    end

    assign load_data_out = ld_q.en ? load_extend(ram_rdata, ld_q.size, ld_q.lane, ld_q.uns) : '0;

endmodule

// File: tb/tb_mem_access_ls.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_mem_access_ls;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       valid_in, MemRead, MemWrite, mem_unsigned, MemtoReg_in, RegWrite_in;
    logic [1:0]       branch_in, jump_in, zero_in;
    logic [1:0][1:0]  mem_size;
    logic [1:0][31:0] branch_pc_in, address_in, store_data_in;
    logic [1:0][4:0]  rd_in;
    logic [1:0]       stall_out, valid_out, MemtoReg_out, RegWrite_out, PCSrc_out, jump_out, misaligned_out;
    logic [1:0][31:0] load_data_out, alu_result_out, branch_pc_out;
    logic [1:0][4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_ls #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES((g == 0) ? 0 : 3)) dut (
            .clk(clk), .rst_n(rst_n), .valid_in(valid_in[g]), .MemRead(MemRead[g]),
            .MemWrite(MemWrite[g]), .mem_size(mem_size[g]), .mem_unsigned(mem_unsigned[g]),
            .MemtoReg_in(MemtoReg_in[g]), .RegWrite_in(RegWrite_in[g]), .branch_in(branch_in[g]),
            .jump_in(jump_in[g]), .zero_in(zero_in[g]), .branch_pc_in(branch_pc_in[g]),
            .address_in(address_in[g]), .store_data_in(store_data_in[g]), .rd_in(rd_in[g]),
            .stall_out(stall_out[g]), .valid_out(valid_out[g]), .MemtoReg_out(MemtoReg_out[g]),
            .RegWrite_out(RegWrite_out[g]), .load_data_out(load_data_out[g]),
            .alu_result_out(alu_result_out[g]), .rd_out(rd_out[g]), .PCSrc_out(PCSrc_out[g]),
            .jump_out(jump_out[g]), .branch_pc_out(branch_pc_out[g]),
            .misaligned_out(misaligned_out[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i);
        valid_in[i] = 0; MemRead[i] = 0; MemWrite[i] = 0; mem_unsigned[i] = 0;
        MemtoReg_in[i] = 0; RegWrite_in[i] = 0; branch_in[i] = 0; jump_in[i] = 0;
        zero_in[i] = 0; mem_size[i] = 2'b10; branch_pc_in[i] = 0; rd_in[i] = 0;
        address_in[i] = 0; store_data_in[i] = 0;
    endtask

    task automatic set_mem(input int i, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] data);
        idle(i);
        valid_in[i] = 1; MemRead[i] = rd; MemWrite[i] = wr; mem_size[i] = sz;
        mem_unsigned[i] = uns; address_in[i] = addr; store_data_in[i] = data;
        RegWrite_in[i] = rd; MemtoReg_in[i] = rd; rd_in[i] = 5'd7;
    endtask

    // Counts stall-high cycles and edges until valid_out on the wait instance.
    task automatic measure(output int n_stall, output int lat);
        n_stall = 0;
        lat     = 0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (stall_out[1] === 1'b1) n_stall++;
            tick();
            if (valid_out[1] === 1'b1) begin
                lat = c + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [138:0] o;
        idle(0); idle(1);
        rst_n = 0;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            o = {stall_out[i], valid_out[i], MemtoReg_out[i], RegWrite_out[i], load_data_out[i],
                 alu_result_out[i], rd_out[i], PCSrc_out[i], jump_out[i], branch_pc_out[i],
                 misaligned_out[i], 32'h0};
            n_checks++;
            if (o !== '0) begin n_fail++; $display("FAIL reset_outputs[%0d]: got %h want 0", i, o); end
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_w0_store_load();
        set_mem(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        #1;
        n_checks++; if (stall_out[0] !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %b want 0", stall_out[0]); end
        tick();
        n_checks++; if (valid_out[0] !== 1'b1) begin n_fail++; $display("FAIL sw_valid: got %b want 1", valid_out[0]); end
        n_checks++; if (RegWrite_out[0] !== 1'b0) begin n_fail++; $display("FAIL sw_regwrite: got %b want 0", RegWrite_out[0]); end
        set_mem(0, 1, 0, 2'b10, 0, 32'h10, 32'h0);
        #1;
        n_checks++; if (stall_out[0] !== 1'b0) begin n_fail++; $display("FAIL lw_stall: got %b want 0", stall_out[0]); end
        tick();
        n_checks++; if (load_data_out[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", load_data_out[0]); end
        n_checks++; if ({valid_out[0], RegWrite_out[0], MemtoReg_out[0], rd_out[0]} !== {3'b111, 5'd7}) begin
            n_fail++; $display("FAIL lw_ctrl: got %b%b%b rd=%0d want 111 rd=7", valid_out[0], RegWrite_out[0], MemtoReg_out[0], rd_out[0]); end
        n_checks++; if (alu_result_out[0] !== 32'h10) begin n_fail++; $display("FAIL lw_alu: got %h want 10", alu_result_out[0]); end
        idle(0);
        tick();
        n_checks++; if ({valid_out[0], RegWrite_out[0]} !== 2'b00) begin n_fail++; $display("FAIL bubble_ctrl: got %b%b want 00", valid_out[0], RegWrite_out[0]); end
        n_checks++; if (load_data_out[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bubble_hold: got %h want deadbeef", load_data_out[0]); end
    endtask

    task automatic test_byte();
        set_mem(0, 0, 1, 2'b10, 0, 32'h20, 32'h11223344); tick();
        set_mem(0, 0, 1, 2'b00, 0, 32'h21, 32'hABCDEF80); tick();
        set_mem(0, 1, 0, 2'b00, 0, 32'h21, 32'h0); tick();
        n_checks++; if (load_data_out[0] !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb: got %h want ffffff80", load_data_out[0]); end
        set_mem(0, 1, 0, 2'b00, 1, 32'h21, 32'h0); tick();
        n_checks++; if (load_data_out[0] !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", load_data_out[0]); end
        set_mem(0, 1, 0, 2'b10, 0, 32'h20, 32'h0); tick();
        n_checks++; if (load_data_out[0] !== 32'h11228044) begin n_fail++; $display("FAIL sb_word: got %h want 11228044", load_data_out[0]); end
    endtask

    task automatic test_half();
        set_mem(0, 0, 1, 2'b10, 0, 32'h30, 32'h55667788); tick();
        set_mem(0, 0, 1, 2'b01, 0, 32'h32, 32'h12348001); tick();
        set_mem(0, 1, 0, 2'b01, 0, 32'h32, 32'h0); tick();
        n_checks++; if (load_data_out[0] !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh: got %h want ffff8001", load_data_out[0]); end
        set_mem(0, 1, 0, 2'b01, 1, 32'h32, 32'h0); tick();
        n_checks++; if (load_data_out[0] !== 32'h00008001) begin n_fail++; $display("FAIL lhu: got %h want 00008001", load_data_out[0]); end
        set_mem(0, 1, 0, 2'b01, 0, 32'h33, 32'h0); tick();
        n_checks++; if ({valid_out[0], misaligned_out[0], RegWrite_out[0]} !== 3'b110) begin
            n_fail++; $display("FAIL lh_mis_flags: got %b%b%b want 110", valid_out[0], misaligned_out[0], RegWrite_out[0]); end
        n_checks++; if (load_data_out[0] !== 32'h0) begin n_fail++; $display("FAIL lh_mis_data: got %h want 0", load_data_out[0]); end
        set_mem(0, 0, 1, 2'b01, 0, 32'h31, 32'hFFFFFFFF); tick();
        set_mem(0, 0, 1, 2'b10, 0, 32'h32, 32'hFFFFFFFF); tick();
        set_mem(0, 1, 0, 2'b10, 0, 32'h30, 32'h0); tick();
        n_checks++; if ({misaligned_out[0], load_data_out[0]} !== {1'b0, 32'h80017788}) begin
            n_fail++; $display("FAIL mis_store_nowrite: got %b %h want 0 80017788", misaligned_out[0], load_data_out[0]); end
    endtask

    task automatic test_rbw_alias();
        set_mem(0, 1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D); tick();
        n_checks++; if (load_data_out[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rbw_old: got %h want deadbeef", load_data_out[0]); end
        set_mem(0, 1, 0, 2'b10, 0, 32'h1010, 32'h0); tick();
        n_checks++; if (load_data_out[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_new: got %h want cafef00d", load_data_out[0]); end
    endtask

    task automatic test_branch();
        idle(0);
        valid_in[0] = 1; branch_in[0] = 1; zero_in[0] = 1; branch_pc_in[0] = 32'h100;
        tick();
        n_checks++; if ({PCSrc_out[0], branch_pc_out[0]} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL br_taken: got %b %h want 1 00000100", PCSrc_out[0], branch_pc_out[0]); end
        n_checks++; if (load_data_out[0] !== 32'h0) begin n_fail++; $display("FAIL nonmem_data: got %h want 0", load_data_out[0]); end
        zero_in[0] = 0;
        tick();
        n_checks++; if (PCSrc_out[0] !== 1'b0) begin n_fail++; $display("FAIL br_not_taken: got %b want 0", PCSrc_out[0]); end
        branch_in[0] = 0; jump_in[0] = 1; branch_pc_in[0] = 32'h200;
        tick();
        n_checks++; if ({jump_out[0], branch_pc_out[0]} !== {1'b1, 32'h200}) begin
            n_fail++; $display("FAIL jump: got %b %h want 1 00000200", jump_out[0], branch_pc_out[0]); end
        idle(0);
        tick();
        n_checks++; if (jump_out[0] !== 1'b0) begin n_fail++; $display("FAIL jump_bubble: got %b want 0", jump_out[0]); end
    endtask

    task automatic test_wait();
        int ns, lat;
        set_mem(1, 0, 1, 2'b10, 0, 32'h40, 32'hA5A5A5A5);
        measure(ns, lat);
        n_checks++; if ({ns, lat} !== {32'd3, 32'd4}) begin n_fail++; $display("FAIL sw_wait: stalls=%0d lat=%0d want 3 4", ns, lat); end
        set_mem(1, 1, 0, 2'b10, 0, 32'h40, 32'h0);
        measure(ns, lat);
        n_checks++; if ({ns, lat} !== {32'd3, 32'd4}) begin n_fail++; $display("FAIL lw_wait: stalls=%0d lat=%0d want 3 4", ns, lat); end
        n_checks++; if (load_data_out[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL lw_wait_data: got %h want a5a5a5a5", load_data_out[1]); end
        set_mem(1, 1, 0, 2'b10, 0, 32'h42, 32'h0);
        #1;
        n_checks++; if (stall_out[1] !== 1'b0) begin n_fail++; $display("FAIL mis_nostall: got %b want 0", stall_out[1]); end
        tick();
        n_checks++; if ({valid_out[1], misaligned_out[1]} !== 2'b11) begin n_fail++; $display("FAIL mis_wait: got %b%b want 11", valid_out[1], misaligned_out[1]); end
    endtask

    task automatic test_reset_in_wait();
        int ns, lat;
        set_mem(1, 0, 1, 2'b10, 0, 32'h40, 32'h12345678);
        tick(); tick();
        rst_n = 0;
        idle(1);
        tick();
        n_checks++; if ({stall_out[1], valid_out[1], RegWrite_out[1], load_data_out[1], alu_result_out[1]} !== '0) begin
            n_fail++; $display("FAIL rst_wait_outputs: got %b%b%b %h %h want 0", stall_out[1], valid_out[1], RegWrite_out[1], load_data_out[1], alu_result_out[1]); end
        rst_n = 1;
        set_mem(1, 1, 0, 2'b10, 0, 32'h40, 32'h0);
        measure(ns, lat);
        n_checks++; if ({ns, lat} !== {32'd3, 32'd4}) begin n_fail++; $display("FAIL rst_wait_idle: stalls=%0d lat=%0d want 3 4", ns, lat); end
        n_checks++; if (load_data_out[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rst_wait_nowrite: got %h want a5a5a5a5", load_data_out[1]); end
    endtask

    initial begin
        test_reset();
        test_w0_store_load();
        test_byte();
        test_half();
        test_rbw_alias();
        test_branch();
        idle(0);
        test_wait();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
